// File: rtl/gmt_rx_deserializer.sv
// gmt_rx_deserializer: Manchester GMT frame receiver with start-edge timestamp; define GMTRX_GLITCH_FILTER_EN for a 3-tap majority glitch filter
module gmt_rx_deserializer #(
    parameter int g_bit_period    = 124,
    parameter int g_resync_window = 8,
    parameter int g_data_bits     = 32
) (
    input  logic                   clk_sys_i,
    input  logic                   rst_n_sys_i,
    input  logic                   enable_i,
    input  logic                   gmt_i,
    input  logic                   tm_valid_i,
    input  logic [27:0]            tm_cycles_i,
    output logic [g_data_bits-1:0] rx_data_o,
    output logic [27:0]            rx_tstamp_o,
    output logic                   rx_tstamp_valid_o,
    output logic                   rx_valid_o,
    output logic                   rx_err_o,
    output logic [1:0]             rx_err_code_o,
    output logic                   busy_o
);
    localparam int PW = $clog2(g_bit_period);
    localparam int BW = g_data_bits > 1 ? $clog2(g_data_bits) : 1;
    localparam logic [PW-1:0] PH_A    = PW'(g_bit_period / 4);
    localparam logic [PW-1:0] PH_B    = PW'(3 * g_bit_period / 4);
    localparam logic [PW-1:0] PH_MID  = PW'(g_bit_period / 2);
    localparam logic [PW-1:0] PH_LO   = PW'(g_bit_period / 2 - g_resync_window);
    localparam logic [PW-1:0] PH_HI   = PW'(g_bit_period / 2 + g_resync_window);
    localparam logic [PW-1:0] PH_LAST = PW'(g_bit_period - 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;
    localparam logic [2:0] S_GAP   = 3'd6;

    logic                   s1, s2, ln, ln_d;
    logic                   ln_edge, ln_rise, smp;
    logic [2:0]             state;
    logic [PW-1:0]          phase, gap_cnt;
    logic                   a, par, viol, tsv;
    logic [g_data_bits-1:0] sh;
    logic [BW-1:0]          idx;
    logic [27:0]            ts;
    logic [1:0]             err_q;

    assign ln_edge = ln ^ ln_d;
    assign ln_rise = ln & ~ln_d;
    assign smp     = phase == PH_B;

    always_ff @(posedge clk_sys_i or negedge rst_n_sys_i)
        if (!rst_n_sys_i) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            ln_d <= 1'b0;
        end else begin
            s1   <= gmt_i;
            s2   <= s1;
            ln_d <= ln;
        end

`ifdef GMTRX_GLITCH_FILTER_EN
    logic [2:0] taps;
    always_ff @(posedge clk_sys_i or negedge rst_n_sys_i)
        if (!rst_n_sys_i) begin
            taps <= '0;
            ln   <= 1'b0;
        end else begin
            taps <= {taps[1:0], s2};
            ln   <= (taps[0] & taps[1]) | (taps[1] & taps[2]) | (taps[0] & taps[2]);
        end
`else
    always_ff @(posedge clk_sys_i or negedge rst_n_sys_i)
        if (!rst_n_sys_i) ln <= 1'b0;
        else ln <= s2;
`endif

    always_ff @(posedge clk_sys_i or negedge rst_n_sys_i)
        if (!rst_n_sys_i) begin
            state             <= S_IDLE;
            phase             <= '0;
            gap_cnt           <= '0;
            a                 <= 1'b0;
            par               <= 1'b0;
            viol              <= 1'b0;
            tsv               <= 1'b0;
            sh                <= '0;
            idx               <= '0;
            ts                <= '0;
            err_q             <= 2'b00;
            rx_data_o         <= '0;
            rx_tstamp_o       <= '0;
            rx_tstamp_valid_o <= 1'b0;
            rx_valid_o        <= 1'b0;
            rx_err_o          <= 1'b0;
            rx_err_code_o     <= 2'b00;
            busy_o            <= 1'b0;
        end else begin
            rx_valid_o    <= 1'b0;
            rx_err_o      <= 1'b0;
            rx_err_code_o <= 2'b00;
            busy_o        <= state != S_IDLE;
            // a line edge near mid-bit is the Manchester transition: snap the bit phase to it
            if (state == S_IDLE) phase <= '0;
            else if (ln_edge && phase >= PH_LO && phase <= PH_HI) phase <= PH_MID;
            else phase <= phase == PH_LAST ? '0 : phase + 1'b1;
            if (phase == PH_A) a <= ln;
            if (!enable_i && state != S_IDLE && state != S_ERR) begin
                state <= S_ERR;
                err_q <= 2'b11;
            end else begin
                case (state)
                    S_IDLE: if (enable_i && ln_rise) begin
                        ts    <= tm_cycles_i;
                        tsv   <= tm_valid_i;
                        par   <= 1'b0;
                        viol  <= 1'b0;
                        state <= S_START;
                    end
                    S_START: if (smp) begin
                        state <= a && !ln ? S_DATA : S_ERR;
                        err_q <= 2'b01;
                        idx   <= BW'(g_data_bits - 1);
                    end
                    S_DATA: if (smp) begin
                        sh   <= (sh << 1) | g_data_bits'(a);
                        par  <= par ^ a;
                        viol <= viol | (a == ln);
                        idx  <= idx - 1'b1;
                        if (idx == '0) state <= S_PAR;
                    end
                    S_PAR: if (smp) begin
                        state <= !viol && a != ln && (par ^ a) ? S_DONE : S_ERR;
                        err_q <= viol || a == ln ? 2'b01 : 2'b10;
                    end
                    S_DONE: begin
                        rx_data_o         <= sh;
                        rx_tstamp_o       <= ts;
                        rx_tstamp_valid_o <= tsv;
                        rx_valid_o        <= 1'b1;
                        gap_cnt           <= '0;
                        state             <= S_GAP;
                    end
                    S_ERR: begin
                        rx_err_o      <= 1'b1;
                        rx_err_code_o <= err_q;
                        gap_cnt       <= '0;
                        state         <= err_q == 2'b11 || !enable_i ? S_IDLE : S_GAP;
                    end
                    S_GAP: begin
                        gap_cnt <= ln ? '0 : gap_cnt + 1'b1;
                        if (!ln && gap_cnt == PH_LAST) state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
endmodule

// File: tb/tb_gmt_rx_deserializer.sv
// tb_gmt_rx_deserializer: vector table and scoreboard bench for gmt_rx_deserializer
module tb_gmt_rx_deserializer;
    localparam int P = 124;
`ifdef GMTRX_GLITCH_FILTER_EN
    localparam int OFS = 5;
`else
    localparam int OFS = 3;
`endif

    logic        clk_sys_i = 1'b0;
    logic        rst_n_sys_i = 1'b1;
    logic        enable_i = 1'b0;
    logic        gmt_i = 1'b0;
    logic        tm_valid_i = 1'b1;
    logic [27:0] tm_cycles_i = 28'hFFFFFF0;
    logic [31:0] rx_data_o;
    logic [27:0] rx_tstamp_o;
    logic        rx_tstamp_valid_o, rx_valid_o, rx_err_o, busy_o;
    logic [1:0]  rx_err_code_o;

    typedef struct {
        logic        ok;
        logic [31:0] data;
        logic [27:0] ts;
        logic        tsv;
        logic [1:0]  code;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        int          per;
        logic        pflip;
        logic        tmv;
        logic        ok;
        logic [1:0]  code;
    } vec_t;

    exp_t        sb[$];
    exp_t        me;
    vec_t        vt[7];
    int          n_total = 0;
    int          n_bad = 0;
    logic [31:0] last_d = '0;
    logic [27:0] last_ts = '0;
    logic        last_tsv = 1'b0;

    gmt_rx_deserializer dut (
        .clk_sys_i(clk_sys_i), .rst_n_sys_i(rst_n_sys_i), .enable_i(enable_i), .gmt_i(gmt_i),
        .tm_valid_i(tm_valid_i), .tm_cycles_i(tm_cycles_i), .rx_data_o(rx_data_o),
        .rx_tstamp_o(rx_tstamp_o), .rx_tstamp_valid_o(rx_tstamp_valid_o), .rx_valid_o(rx_valid_o),
        .rx_err_o(rx_err_o), .rx_err_code_o(rx_err_code_o), .busy_o(busy_o)
    );

    always #4 clk_sys_i = ~clk_sys_i;
    always @(posedge clk_sys_i) tm_cycles_i <= tm_cycles_i + 28'd1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk_sys_i)
        if (!rst_n_sys_i) begin
            last_d   <= '0;
            last_ts  <= '0;
            last_tsv <= 1'b0;
        end else if (rx_valid_o || rx_err_o) begin
            chk("valid_err_excl", 64'(rx_valid_o & rx_err_o), 0);
            if (sb.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL unexpected_strobe: valid=%0b err=%0b code=%0b expected none", rx_valid_o, rx_err_o, rx_err_code_o);
            end else begin
                me = sb.pop_front();
                chk("strobe_kind", 64'(rx_valid_o), 64'(me.ok));
                chk("err_code", 64'(rx_err_code_o), 64'(me.code));
                if (me.ok) begin
                    chk("rx_data", 64'(rx_data_o), 64'(me.data));
                    chk("rx_tstamp", 64'(rx_tstamp_o), 64'(me.ts));
                    chk("rx_tstamp_valid", 64'(rx_tstamp_valid_o), 64'(me.tsv));
                    last_d   <= me.data;
                    last_ts  <= me.ts;
                    last_tsv <= me.tsv;
                end else begin
                    chk("hold_data", 64'(rx_data_o), 64'(last_d));
                    chk("hold_tstamp", 64'(rx_tstamp_o), 64'(last_ts));
                    chk("hold_tsv", 64'(rx_tstamp_valid_o), 64'(last_tsv));
                end
            end
        end

    task automatic send_frame(input logic [31:0] d, input int per, input logic pflip, input int hold_bit,
                              input logic push, input logic ok, input logic [1:0] code);
        logic [33:0] bits;
        logic        flat;
        bits = {1'b1, d, ~(^d) ^ pflip};
        @(negedge clk_sys_i);
        if (push) sb.push_back('{ok, d, tm_cycles_i + 28'(OFS), tm_valid_i, code});
        for (int i = 33; i >= 0; i--) begin
            flat = hold_bit >= 0 && i == hold_bit + 1;
            gmt_i = flat ? 1'b1 : bits[i];
            repeat (per / 2) @(negedge clk_sys_i);
            gmt_i = flat ? 1'b1 : ~bits[i];
            repeat (per / 2) @(negedge clk_sys_i);
        end
        gmt_i = 1'b0;
    endtask

    task automatic drain(input int n);
        int i;
        i = 0;
        while (sb.size() != 0 && i < n) begin
            @(negedge clk_sys_i);
            i++;
        end
        if (sb.size() != 0) begin
            n_total++;
            n_bad++;
            $display("FAIL drain_timeout: %0d strobes outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        logic seen;
        int   n;
        vt[0] = '{32'hDEADBEEF, 124, 1'b0, 1'b1, 1'b1, 2'b00};
        vt[1] = '{32'h00000001, 124, 1'b1, 1'b1, 1'b0, 2'b10};
        vt[2] = '{32'hA5A55A5A, 120, 1'b0, 1'b1, 1'b1, 2'b00};
        vt[3] = '{32'hA5A55A5A, 128, 1'b0, 1'b1, 1'b1, 2'b00};
        vt[4] = '{32'h0F0F1234, 124, 1'b0, 1'b0, 1'b1, 2'b00};
        vt[5] = '{32'hFFFFFFFF, 124, 1'b0, 1'b1, 1'b1, 2'b00};
        vt[6] = '{32'h00000000, 124, 1'b0, 1'b1, 1'b1, 2'b00};

        #1 rst_n_sys_i = 1'b0;
        repeat (3) @(negedge clk_sys_i);
        chk("rst_data", 64'(rx_data_o), 0);
        chk("rst_tstamp", 64'(rx_tstamp_o), 0);
        chk("rst_tsv", 64'(rx_tstamp_valid_o), 0);
        chk("rst_valid", 64'(rx_valid_o), 0);
        chk("rst_err", 64'(rx_err_o), 0);
        chk("rst_code", 64'(rx_err_code_o), 0);
        chk("rst_busy", 64'(busy_o), 0);
        rst_n_sys_i = 1'b1;
        repeat (10) @(negedge clk_sys_i);

        seen = 1'b0;
        gmt_i = 1'b1;
        repeat (10) @(negedge clk_sys_i) seen |= busy_o;
        gmt_i = 1'b0;
        repeat (10) @(negedge clk_sys_i) seen |= busy_o;
        chk("disabled_idle_busy", 64'(seen), 0);
        enable_i = 1'b1;
        repeat (10) @(negedge clk_sys_i);

        for (int i = 0; i < 7; i++) begin
            tm_valid_i = vt[i].tmv;
            send_frame(vt[i].data, vt[i].per, vt[i].pflip, -1, 1'b1, vt[i].ok, vt[i].code);
            tm_valid_i = 1'b1;
            repeat (2 * P) @(negedge clk_sys_i);
            drain(4 * P);
        end

        send_frame(32'h00000007, P, 1'b0, 20, 1'b1, 1'b0, 2'b01);
        repeat (P) @(negedge clk_sys_i);
        chk("gap_busy_hold", 64'(busy_o), 1);
        n = 0;
        while (busy_o && n < 20) begin
            @(negedge clk_sys_i);
            n++;
        end
        chk("gap_busy_fall", 64'(busy_o), 0);
        drain(4 * P);

        fork
            send_frame(32'hCAFEF00D, P, 1'b0, -1, 1'b1, 1'b0, 2'b11);
            begin
                @(negedge clk_sys_i);
                repeat (22 * P + P / 2) @(negedge clk_sys_i);
                enable_i = 1'b0;
                repeat (2) @(negedge clk_sys_i);
                chk("dis_err", 64'(rx_err_o), 1);
                chk("dis_code", 64'(rx_err_code_o), 2'b11);
                @(negedge clk_sys_i);
                chk("dis_busy", 64'(busy_o), 0);
                chk("dis_err_single", 64'(rx_err_o), 0);
            end
        join
        repeat (2 * P) @(negedge clk_sys_i);
        enable_i = 1'b1;
        send_frame(32'h12345678, P, 1'b0, -1, 1'b1, 1'b1, 2'b00);
        repeat (2 * P) @(negedge clk_sys_i);
        drain(4 * P);

        fork
            send_frame(32'h55AA33CC, P, 1'b0, -1, 1'b0, 1'b0, 2'b00);
            begin
                @(negedge clk_sys_i);
                repeat (10 * P) @(negedge clk_sys_i);
                rst_n_sys_i = 1'b0;
                #1;
                chk("midrst_busy", 64'(busy_o), 0);
                chk("midrst_data", 64'(rx_data_o), 0);
                chk("midrst_tstamp", 64'(rx_tstamp_o), 0);
            end
        join
        repeat (P) @(negedge clk_sys_i);
        rst_n_sys_i = 1'b1;
        repeat (P) @(negedge clk_sys_i);

        send_frame(32'h11111111, P, 1'b0, -1, 1'b1, 1'b1, 2'b00);
        repeat (2 * P) @(negedge clk_sys_i);
        send_frame(32'h22222222, P, 1'b0, -1, 1'b1, 1'b1, 2'b00);
        repeat (2 * P) @(negedge clk_sys_i);
        drain(4 * P);

        seen = 1'b0;
        @(negedge clk_sys_i);
        gmt_i = 1'b1;
`ifndef GMTRX_GLITCH_FILTER_EN
        sb.push_back('{1'b0, 32'h0, 28'h0, 1'b0, 2'b01});
`endif
        @(negedge clk_sys_i);
        gmt_i = 1'b0;
        repeat (20) @(negedge clk_sys_i) seen |= busy_o;
`ifdef GMTRX_GLITCH_FILTER_EN
        chk("glitch_busy", 64'(seen), 0);
`else
        chk("glitch_busy", 64'(seen), 1);
`endif
        drain(4 * P);
        repeat (2 * P) @(negedge clk_sys_i);

        chk("sb_empty", 64'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
